obi_sram_responder: RTL and testbench
=====================================

# obi_sram_responder

Synthesizable OBI data-port responder: accepts requests from one OBI initiator (the core's data port or a crossbar slave output), performs byte-enabled reads and writes on an internal word-addressed SRAM array, and returns in-order responses a fixed number of cycles after each grant. It sits at the responder end of the data crossbar, in place of the testbench RAM's data side, so the core and the vector coprocessor can be exercised against a timing-exact, cycle-deterministic memory.

## Interface
- ADDR_WIDTH, 12, word-address bits; array depth 2**ADDR_WIDTH words of 32 bits
- LATENCY, 1, cycles from grant to rvalid; legal range 1..4
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- data_req_i  in  1  request valid
- data_gnt_o  out  1  grant; handshake is req && gnt in the same cycle
- data_addr_i  in  32  byte address; bits [1:0] ignored
- data_we_i  in  1  1 = write, 0 = read
- data_be_i  in  4  byte enables, bit n covers wdata/rdata [8n+7:8n]
- data_wdata_i  in  32  write data
- data_rvalid_o  out  1  response valid, one cycle per accepted request
- data_rdata_o  out  32  read data; 0 on write responses
- txn_count_o  out  32  count of accepted requests, wraps 2**32-1 -> 0

## Operation
- Word index = addr[ADDR_WIDTH+1:2]; out of range when addr[31:ADDR_WIDTH+2] != 0.
- On handshake:
  - Write: array bytes with be=1 updated at that clock edge. Out-of-range writes are dropped.
  - Read: word sampled at that clock edge, all four bytes, be ignored. Out-of-range reads return 32'h0.
- Read-after-write:
  - A read granted in the cycle after a write to the same word returns the new data.
  - There is no same-cycle hazard, because only one request is accepted per cycle.
- Response pipeline: LATENCY stages, each holding {valid, rdata}. The handshake loads stage 0; the last stage drives data_rvalid_o / data_rdata_o.
- Responses are strictly in order. There is no rready, and the initiator must always accept.
- data_gnt_o = 1 whenever not in reset (subject to Configuration). Grant may be asserted without req; it is combinational from state only, never from data_req_i.
- txn_count_o increments by 1 per handshake.

## Timing
- Handshake at cycle N produces data_rvalid_o=1 in cycle N+LATENCY, exactly one cycle wide.
- Back-to-back handshakes at N and N+1 produce rvalid at N+LATENCY and N+LATENCY+1; sustained throughput is 1 request per cycle.
- Maximum in flight = LATENCY; no counter or limit logic is needed.
- Reset values:
  - data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0, txn_count_o=0.
  - All pipeline stages are cleared.
  - Array contents are not reset.
- Reset asserted mid-operation drops in-flight responses; no rvalid follows the deassertion.
- data_gnt_o returns to 1 in the first cycle after rst_i deasserts.

## Configuration
- OBI_RESP_STALL_EN defined: grant-stall injection is compiled in.
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - data_gnt_o = ~lfsr[1] | ~lfsr[0]: a request is stalled whenever both bits are 1, roughly 25% of cycles.
  - An initiator holding req keeps address and data stable until granted; the responder does not check this.
- OBI_RESP_STALL_EN undefined: no LFSR; data_gnt_o is constant 1 outside reset.

## Structure
- Shared package obi_resp_pkg:
  - typedef resp_stage_t {logic valid; logic [31:0] rdata;}
  - LFSR seed and tap constants
  - MAX_LATENCY=4
- One sub-module, obi_resp_lfsr (step, state out), instantiated only under OBI_RESP_STALL_EN.
- Array, pipeline and counter live in the top module.
- Elaboration-time assertion: 1 <= LATENCY <= MAX_LATENCY.

## Test plan
- LATENCY=1, macro off: write 0x12345678 be=4'hF to 0x40, then read 0x40 -> rvalid 1 cycle after the read grant, rdata=0x12345678; txn_count_o=2.
- Byte enables: write 0xFFFFFFFF to 0x80, then write 0xAABBCCDD be=4'b0101, then read 0x80 -> 0xFFBBFFDD.
- LATENCY=3, four back-to-back reads of preloaded words A..D -> rvalid high for 4 consecutive cycles starting at grant+3, data in order A,B,C,D.
- Out of range (ADDR_WIDTH=12): write to 0x0001_0000, then read 0x0001_0000 -> rdata=0; read 0x0 is unchanged.
- Reset mid-flight: LATENCY=2, grant a read, assert rst_i the next cycle -> no rvalid ever appears for that read; all outputs 0 during reset; gnt=1 one cycle after release.
- Macro on: 1000 cycles of req held high -> grant duty cycle 70-80%; each rvalid follows its own grant by exactly LATENCY cycles; txn_count_o equals the number of rvalids.

Source files
------------

// File: rtl/obi_resp_pkg.sv
// obi_resp_pkg
// Shared types and constants for the OBI SRAM responder.
//   resp_stage_t : one response pipeline stage {valid, rdata}
//   MAX_LATENCY  : deepest supported response pipeline
//   LFSR_SEED    : reset value of the grant-stall LFSR
//   LFSR_TAPS    : feedback mask for taps 16,14,13,11 (state bits 15,13,12,10)
package obi_resp_pkg;

    localparam int          MAX_LATENCY = 4;
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
    } resp_stage_t;

endpackage

// File: rtl/obi_resp_lfsr.sv
// obi_resp_lfsr
// 16-bit Fibonacci LFSR used to inject pseudo-random grant stalls.
// Ports:
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset, loads LFSR_SEED
//   step_i  : advance the sequence by one position this cycle
//   state_o : current LFSR state
module obi_resp_lfsr
    import obi_resp_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        step_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Shift left; the new LSB is the XOR of the tapped bits.
    always_comb begin
        state_d = state_q;
        if (step_i) begin
            state_d = {state_q[14:0], ^(state_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/obi_sram_responder.sv
// obi_sram_responder
// OBI data-port responder backed by a word-addressed SRAM array. Requests are
// accepted one per cycle and answered in order exactly LATENCY cycles after
// their grant.
// Parameters:
//   ADDR_WIDTH : word-address bits; array holds 2**ADDR_WIDTH 32-bit words
//   LATENCY    : grant-to-rvalid delay in cycles, 1..MAX_LATENCY
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   data_req_i     : request valid
//   data_gnt_o     : grant (handshake is req && gnt)
//   data_addr_i    : byte address, bits [1:0] ignored
//   data_we_i      : 1 = write, 0 = read
//   data_be_i      : byte enables for writes
//   data_wdata_i   : write data
//   data_rvalid_o  : response valid, one per accepted request
//   data_rdata_o   : read data, 0 for write responses
//   txn_count_o    : number of accepted requests (wrapping)
// Build option:
//   OBI_RESP_STALL_EN : when defined, an LFSR withholds grant ~25% of cycles.
module obi_sram_responder
    import obi_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic [31:0] txn_count_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    generate
        if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
            $error("obi_sram_responder: LATENCY must be within 1..MAX_LATENCY");
        end
    endgenerate

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  in_range;
    logic                  handshake;
    logic [1:0]            unused_addr_bits;

    resp_stage_t stage_q [LATENCY];
    resp_stage_t stage_d [LATENCY];
    logic [31:0] txn_count_q;
    logic [31:0] txn_count_d;

    assign word_idx         = data_addr_i[ADDR_WIDTH+1:2];
    assign in_range         = (data_addr_i[31:ADDR_WIDTH+2] == '0);
    assign handshake        = data_req_i & data_gnt_o;
    assign unused_addr_bits = data_addr_i[1:0];

`ifdef OBI_RESP_STALL_EN
    logic [15:0] lfsr_state;
    logic [13:0] unused_lfsr_bits;

    obi_resp_lfsr u_lfsr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .step_i  (1'b1),
        .state_o (lfsr_state)
    );

    assign unused_lfsr_bits = lfsr_state[15:2];

    // Stall only when both low LFSR bits are set (about one cycle in four).
    assign data_gnt_o = ~rst_i & (~lfsr_state[1] | ~lfsr_state[0]);
`else
    // Grant depends only on reset so it can never form a loop with req.
    assign data_gnt_o = ~rst_i;
`endif

    // The array has no reset; writes land at the handshake edge, so a read
    // granted in the next cycle already sees the new contents.
    always_ff @(posedge clk_i) begin
        if (handshake && data_we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Stage 0 captures the response of this cycle's handshake; later stages
    // simply shift, which keeps responses in order and fixed-latency.
    always_comb begin
        stage_d = stage_q;
        stage_d[0].valid = handshake;
        stage_d[0].rdata = '0;
        if (handshake && !data_we_i && in_range) begin
            stage_d[0].rdata = mem[word_idx];
        end
        for (int i = 1; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_comb begin
        txn_count_d = txn_count_q;
        if (handshake) begin
            txn_count_d = txn_count_q + 32'd1;
        end
    end

    // Reset empties the pipeline so in-flight responses are dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
            txn_count_q <= '0;
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= stage_d[i];
            end
            txn_count_q <= txn_count_d;
        end
    end

    assign data_rvalid_o = stage_q[LATENCY-1].valid;
    assign data_rdata_o  = stage_q[LATENCY-1].rdata;
    assign txn_count_o   = txn_count_q;

endmodule

// File: tb/tb_obi_sram_responder.sv
// tb_obi_sram_responder
// Directed scoreboard bench for obi_sram_responder. Each granted request pushes
// its expected response and due cycle; a negedge monitor pops and compares.
module tb_obi_sram_responder;

    localparam int LAT = 3;
    localparam int AW  = 12;

    logic        clk;
    logic        rst;
    logic        data_req_i;
    logic        data_gnt_o;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic [31:0] txn_count_o;

    typedef struct {
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   exp_txn     = 0;
    int   rv_count    = 0;

    obi_sram_responder #(
        .ADDR_WIDTH (AW),
        .LATENCY    (LAT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .data_req_i    (data_req_i),
        .data_gnt_o    (data_gnt_o),
        .data_addr_i   (data_addr_i),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_wdata_i  (data_wdata_i),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .txn_count_o   (txn_count_o)
    );

    // Free-running clock and a cycle counter advanced at every rising edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Hard stop in case something hangs.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every rvalid must match the oldest outstanding expectation in
    // both data and arrival cycle; an overdue expectation is a missed response.
    always @(negedge clk) begin
        if (data_rvalid_o === 1'b1) begin
            rv_count++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("rdata", data_rdata_o, mon_e.rdata);
                checkOutput("rvalid_cycle", 32'(cyc), 32'(mon_e.due));
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            mon_e = exp_q.pop_front();
            checkOutput("missing_rvalid", 32'd0, 32'd1);
        end
    end

    // Drive one request (called at negedge+1) and hold it until granted.
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata);
        bit done;
        exp_t e;
        done = 1'b0;
        data_req_i   = 1'b1;
        data_we_i    = we;
        data_addr_i  = addr;
        data_be_i    = be;
        data_wdata_i = wdata;
        for (int t = 0; t < 50 && !done; t++) begin
            #3;
            if (data_gnt_o === 1'b1) begin
                e.rdata = exp_rdata;
                e.due   = cyc + LAT;
                exp_q.push_back(e);
                exp_txn++;
                done = 1'b1;
            end
            @(negedge clk);
            #1;
        end
        if (!done) checkOutput("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        data_req_i = 1'b0;
        data_we_i  = 1'b0;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drain();
        data_req_i = 1'b0;
        for (int t = 0; t < 30 && exp_q.size() != 0; t++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int rv_before;
        int grants;
        int txn_base;
        rst          = 1'b1;
        data_req_i   = 1'b0;
        data_addr_i  = '0;
        data_we_i    = 1'b0;
        data_be_i    = '0;
        data_wdata_i = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_gnt", {31'd0, data_gnt_o}, 32'd0);
        checkOutput("reset_rvalid", {31'd0, data_rvalid_o}, 32'd0);
        checkOutput("reset_rdata", data_rdata_o, 32'd0);
        checkOutput("reset_txn", txn_count_o, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("gnt_after_reset", {31'd0, data_gnt_o}, 32'd1);
        idle(1);

        // Write then read the same word in the following cycle.
        applyStimulus(1'b1, 32'h0000_0040, 4'hF, 32'h1234_5678, 32'h0);
        applyStimulus(1'b0, 32'h0000_0040, 4'hF, 32'h0,        32'h1234_5678);
        drain();
        checkOutput("txn_after_wr_rd", txn_count_o, 32'd2);

        // Partial byte-enable write merges with the previous word.
        applyStimulus(1'b1, 32'h0000_0080, 4'hF,    32'hFFFF_FFFF, 32'h0);
        applyStimulus(1'b1, 32'h0000_0080, 4'b0101, 32'hAABB_CCDD, 32'h0);
        applyStimulus(1'b0, 32'h0000_0082, 4'h0,    32'h0,         32'hFFBB_FFDD);
        drain();

        // Four back-to-back reads of preloaded words come back in order.
        applyStimulus(1'b1, 32'h0000_0100, 4'hF, 32'hA0A0_0001, 32'h0);
        applyStimulus(1'b1, 32'h0000_0104, 4'hF, 32'hB0B0_0002, 32'h0);
        applyStimulus(1'b1, 32'h0000_0108, 4'hF, 32'hC0C0_0003, 32'h0);
        applyStimulus(1'b1, 32'h0000_010C, 4'hF, 32'hD0D0_0004, 32'h0);
        idle(2);
        applyStimulus(1'b0, 32'h0000_0100, 4'hF, 32'h0, 32'hA0A0_0001);
        applyStimulus(1'b0, 32'h0000_0104, 4'hF, 32'h0, 32'hB0B0_0002);
        applyStimulus(1'b0, 32'h0000_0108, 4'hF, 32'h0, 32'hC0C0_0003);
        applyStimulus(1'b0, 32'h0000_010C, 4'hF, 32'h0, 32'hD0D0_0004);
        drain();

        // Out-of-range write is dropped and must not alias onto word 0.
        applyStimulus(1'b1, 32'h0000_0000, 4'hF, 32'h1122_3344, 32'h0);
        applyStimulus(1'b1, 32'h0001_0000, 4'hF, 32'hDEAD_BEEF, 32'h0);
        applyStimulus(1'b0, 32'h0001_0000, 4'hF, 32'h0, 32'h0);
        applyStimulus(1'b0, 32'h0000_0000, 4'hF, 32'h0, 32'h1122_3344);
        applyStimulus(1'b0, 32'h0000_3FFC, 4'hF, 32'h0, 32'h0);
        drain();
        checkOutput("txn_total", txn_count_o, 32'(exp_txn));

        // Idle cycles do not count as transactions.
        idle(4);
        checkOutput("txn_idle", txn_count_o, 32'(exp_txn));

        // Reset one cycle after a read grant drops that response.
        idle(1);
        applyStimulus(1'b0, 32'h0000_0040, 4'hF, 32'h0, 32'h1234_5678);
        rst        = 1'b1;
        data_req_i = 1'b0;
        exp_q.delete();
        exp_txn    = 0;
        rv_before  = rv_count;
        #1;
        checkOutput("midrst_gnt", {31'd0, data_gnt_o}, 32'd0);
        checkOutput("midrst_rvalid", {31'd0, data_rvalid_o}, 32'd0);
        checkOutput("midrst_rdata", data_rdata_o, 32'd0);
        checkOutput("midrst_txn", txn_count_o, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("gnt_after_midrst", {31'd0, data_gnt_o}, 32'd1);
        idle(LAT + 4);
        checkOutput("no_rvalid_after_rst", 32'(rv_count), 32'(rv_before));

        // Array contents survive reset.
        applyStimulus(1'b0, 32'h0000_0080, 4'hF, 32'h0, 32'hFFBB_FFDD);
        drain();
        checkOutput("txn_after_midrst", txn_count_o, 32'd1);

`ifdef OBI_RESP_STALL_EN
        // Request held high for 1000 cycles against the stalling grant.
        grants   = 0;
        txn_base = exp_txn;
        rv_before = rv_count;
        data_req_i   = 1'b1;
        data_we_i    = 1'b0;
        data_addr_i  = 32'h0000_0040;
        data_be_i    = 4'hF;
        for (int i = 0; i < 1000; i++) begin
            #3;
            if (data_gnt_o === 1'b1) begin
                exp_q.push_back('{32'h1234_5678, cyc + LAT});
                grants++;
                exp_txn++;
            end
            @(negedge clk);
            #1;
        end
        drain();
        checkOutput("stall_duty_70_80", 32'(grants >= 700 && grants <= 800), 32'd1);
        checkOutput("stall_txn", txn_count_o, 32'(exp_txn));
        checkOutput("stall_rvalid_count", 32'(rv_count - rv_before), 32'(exp_txn - txn_base));
`else
        grants   = 0;
        txn_base = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
